// File: rtl/dm_pkg.sv
// Shared definitions for the 1-to-4 demux and its upstream dispatcher.
package dm_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [CH_NUM-1:0] chan_vec_t;

endpackage

// File: rtl/dm_fifo.sv
// Synchronous FIFO; one-cycle write-to-read latency, head read from registered storage.
// Backpressure: push ignored when full, pop ignored when empty; simultaneous push/pop at full/empty follows those guards.
module dm_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Empty head reads as zero so stale storage never leaks downstream.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dm_dispatch.sv
// Tags upstream words with a channel (directed or round-robin), buffers them, presents head to the demux.
// Latency: accept edge N visible after edge N; retire only on the head channel's ready; in_ready drops when full.
module dm_dispatch
  import dm_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rr_mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  sel_t             in_dest_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_din_o,
  output sel_t             out_sel_o,
  input  chan_vec_t        chan_ready_i,
  output logic [LW-1:0]    level_o,
  output logic [CNT_W-1:0] xfer_cnt_o
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    sel_t             sel;
  } entry_t;

  entry_t           wr_entry, head_entry;
  logic             fifo_full, fifo_empty;
  logic             acc, ret;
  sel_t             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  assign in_ready_o  = ~fifo_full;
  assign out_valid_o = ~fifo_empty;
  assign acc         = in_valid_i & in_ready_o;
  // Head-of-line: only the head word's channel can release it.
  assign ret         = out_valid_o & chan_ready_i[out_sel_o];

  assign wr_entry.data = in_data_i;
  assign wr_entry.sel  = rr_mode_i ? rr_ptr_q : in_dest_i;

  assign out_din_o  = head_entry.data;
  assign out_sel_o  = head_entry.sel;
  assign xfer_cnt_o = xfer_cnt_q;

  dm_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (acc),
    .wdata_i (wr_entry),
    .pop_i   (ret),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    xfer_cnt_d = xfer_cnt_q;
    if (acc && rr_mode_i) rr_ptr_d = rr_ptr_q + sel_t'(1);
    if (ret) xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      xfer_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

endmodule
